// File: rtl/w_pkg.sv
// Shared geometry and FSM encoding for the layer-2 weight store.
// The layer-2 compute block relies on the same NBANK/AW/DW values.
package w_pkg;

  localparam int unsigned NBANK = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned NWORD = 256;
  localparam int unsigned CW    = 2 * AW;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/w_bank_dec.sv
// Registered 4-to-16 one-hot bank write-enable decoder.
module w_bank_dec
  import w_pkg::*;
(
  input  logic             clk,
  input  logic             xrst,
  input  logic             en,
  input  logic [AW-1:0]    sel,
  output logic [NBANK-1:0] we
);

  logic [NBANK-1:0] we_d;
  logic [NBANK-1:0] we_q;

  always_comb begin
    we_d = '0;
    if (en) we_d[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) we_q <= '0;
    else       we_q <= we_d;
  end

  assign we = we_q;

endmodule

// File: rtl/w2_loader.sv
// Layer-2 weight loader: streams 256 signed bytes into 16 banks, address-major.
// Word n goes to bank n[3:0], address n[7:4]; finish pulses after the last write.
module w2_loader
  import w_pkg::*;
(
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 start,
  output logic                 finish,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 w0_we,
  output logic        [AW-1:0] w0_waddr,
  output logic signed [DW-1:0] w0_wdata,
  output logic                 w1_we,
  output logic        [AW-1:0] w1_waddr,
  output logic signed [DW-1:0] w1_wdata,
  output logic                 w2_we,
  output logic        [AW-1:0] w2_waddr,
  output logic signed [DW-1:0] w2_wdata,
  output logic                 w3_we,
  output logic        [AW-1:0] w3_waddr,
  output logic signed [DW-1:0] w3_wdata,
  output logic                 w4_we,
  output logic        [AW-1:0] w4_waddr,
  output logic signed [DW-1:0] w4_wdata,
  output logic                 w5_we,
  output logic        [AW-1:0] w5_waddr,
  output logic signed [DW-1:0] w5_wdata,
  output logic                 w6_we,
  output logic        [AW-1:0] w6_waddr,
  output logic signed [DW-1:0] w6_wdata,
  output logic                 w7_we,
  output logic        [AW-1:0] w7_waddr,
  output logic signed [DW-1:0] w7_wdata,
  output logic                 w8_we,
  output logic        [AW-1:0] w8_waddr,
  output logic signed [DW-1:0] w8_wdata,
  output logic                 w9_we,
  output logic        [AW-1:0] w9_waddr,
  output logic signed [DW-1:0] w9_wdata,
  output logic                 w10_we,
  output logic        [AW-1:0] w10_waddr,
  output logic signed [DW-1:0] w10_wdata,
  output logic                 w11_we,
  output logic        [AW-1:0] w11_waddr,
  output logic signed [DW-1:0] w11_wdata,
  output logic                 w12_we,
  output logic        [AW-1:0] w12_waddr,
  output logic signed [DW-1:0] w12_wdata,
  output logic                 w13_we,
  output logic        [AW-1:0] w13_waddr,
  output logic signed [DW-1:0] w13_wdata,
  output logic                 w14_we,
  output logic        [AW-1:0] w14_waddr,
  output logic signed [DW-1:0] w14_wdata,
  output logic                 w15_we,
  output logic        [AW-1:0] w15_waddr,
  output logic signed [DW-1:0] w15_wdata
);

  state_t                state_q, state_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic        [AW-1:0]  waddr_q, waddr_d;
  logic signed [DW-1:0]  wdata_q, wdata_d;
  logic                  xfer;
  logic        [NBANK-1:0] we_vec;

  // DONE is entered one cycle after the final accept so finish trails the
  // last write strobe; last_q covers that cycle with in_ready already low.
  assign in_ready = (state_q == LOAD) && !last_q;
  assign finish   = (state_q == DONE);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else if (xfer) begin
          if (cnt_q == CW'(NWORD - 1)) last_d = 1'b1;
          else                         cnt_d  = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      waddr_d = cnt_q[CW-1:AW];
      wdata_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  w_bank_dec u_dec (
    .clk  (clk),
    .xrst (xrst),
    .en   (xfer),
    .sel  (cnt_q[AW-1:0]),
    .we   (we_vec)
  );

  assign w0_we  = we_vec[0];  assign w0_waddr  = waddr_q; assign w0_wdata  = wdata_q;
  assign w1_we  = we_vec[1];  assign w1_waddr  = waddr_q; assign w1_wdata  = wdata_q;
  assign w2_we  = we_vec[2];  assign w2_waddr  = waddr_q; assign w2_wdata  = wdata_q;
  assign w3_we  = we_vec[3];  assign w3_waddr  = waddr_q; assign w3_wdata  = wdata_q;
  assign w4_we  = we_vec[4];  assign w4_waddr  = waddr_q; assign w4_wdata  = wdata_q;
  assign w5_we  = we_vec[5];  assign w5_waddr  = waddr_q; assign w5_wdata  = wdata_q;
  assign w6_we  = we_vec[6];  assign w6_waddr  = waddr_q; assign w6_wdata  = wdata_q;
  assign w7_we  = we_vec[7];  assign w7_waddr  = waddr_q; assign w7_wdata  = wdata_q;
  assign w8_we  = we_vec[8];  assign w8_waddr  = waddr_q; assign w8_wdata  = wdata_q;
  assign w9_we  = we_vec[9];  assign w9_waddr  = waddr_q; assign w9_wdata  = wdata_q;
  assign w10_we = we_vec[10]; assign w10_waddr = waddr_q; assign w10_wdata = wdata_q;
  assign w11_we = we_vec[11]; assign w11_waddr = waddr_q; assign w11_wdata = wdata_q;
  assign w12_we = we_vec[12]; assign w12_waddr = waddr_q; assign w12_wdata = wdata_q;
  assign w13_we = we_vec[13]; assign w13_waddr = waddr_q; assign w13_wdata = wdata_q;
  assign w14_we = we_vec[14]; assign w14_waddr = waddr_q; assign w14_wdata = wdata_q;
  assign w15_we = we_vec[15]; assign w15_waddr = waddr_q; assign w15_wdata = wdata_q;

endmodule

// File: tb/tb_w2_loader.sv
// Directed bench for w2_loader: vector table for reset/idle/first words,
// hand sequences for mid-load reset, full loads, bubbles and back-to-back start.
module tb_w2_loader;

  logic       clk;
  logic       xrst;
  logic       start;
  logic       finish;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       we_u [16];
  logic [3:0] wa   [16];
  logic [7:0] wd   [16];

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [16][16];
  int         tag [16][16];
  int         load_id = 0;
  int         wr_cnt = 0;
  int         fin_cnt = 0;
  int         multi_hot = 0;
  int         bcast_err = 0;

  w2_loader dut (
    .clk(clk), .xrst(xrst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w0_we(we_u[0]),   .w0_waddr(wa[0]),   .w0_wdata(wd[0]),
    .w1_we(we_u[1]),   .w1_waddr(wa[1]),   .w1_wdata(wd[1]),
    .w2_we(we_u[2]),   .w2_waddr(wa[2]),   .w2_wdata(wd[2]),
    .w3_we(we_u[3]),   .w3_waddr(wa[3]),   .w3_wdata(wd[3]),
    .w4_we(we_u[4]),   .w4_waddr(wa[4]),   .w4_wdata(wd[4]),
    .w5_we(we_u[5]),   .w5_waddr(wa[5]),   .w5_wdata(wd[5]),
    .w6_we(we_u[6]),   .w6_waddr(wa[6]),   .w6_wdata(wd[6]),
    .w7_we(we_u[7]),   .w7_waddr(wa[7]),   .w7_wdata(wd[7]),
    .w8_we(we_u[8]),   .w8_waddr(wa[8]),   .w8_wdata(wd[8]),
    .w9_we(we_u[9]),   .w9_waddr(wa[9]),   .w9_wdata(wd[9]),
    .w10_we(we_u[10]), .w10_waddr(wa[10]), .w10_wdata(wd[10]),
    .w11_we(we_u[11]), .w11_waddr(wa[11]), .w11_wdata(wd[11]),
    .w12_we(we_u[12]), .w12_waddr(wa[12]), .w12_wdata(wd[12]),
    .w13_we(we_u[13]), .w13_waddr(wa[13]), .w13_wdata(wd[13]),
    .w14_we(we_u[14]), .w14_waddr(wa[14]), .w14_wdata(wd[14]),
    .w15_we(we_u[15]), .w15_waddr(wa[15]), .w15_wdata(wd[15])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank model: commits whatever the DUT strobes, tagged with the current load.
  always @(posedge clk) begin
    int hot;
    hot = 0;
    if (xrst) begin
      for (int k = 0; k < 16; k++) begin
        if (we_u[k]) begin
          hot++;
          mem[k][wa[k]] <= wd[k];
          tag[k][wa[k]] <= load_id;
        end
      end
      if (finish) fin_cnt <= fin_cnt + 1;
    end
    wr_cnt <= wr_cnt + hot;
    if (hot > 1) multi_hot <= multi_hot + 1;
  end

  always @(negedge clk) begin
    for (int k = 1; k < 16; k++)
      if (wa[k] !== wa[0] || wd[k] !== wd[0]) bcast_err <= bcast_err + 1;
  end

  function automatic logic [15:0] wevec();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = we_u[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input bit gaps, input int n0, input int n1, input bit start_at_100);
    int n;
    int cyc;
    int ph;
    bit acc;
    logic [7:0] dat;
    n = n0; cyc = 0; ph = 0;
    while (n < n1 && cyc < 4000) begin
      in_valid = gaps ? (ph % 3 == 0) : 1'b1;
      ph++;
      dat      = 8'(n) ^ 8'h80;
      in_data  = dat;
      start    = start_at_100 && (n == 100);
      acc      = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        chk("word_we", 32'(wevec()), 32'(16'(1) << (n % 16)));
        chk("word_waddr", 32'(wa[0]), 32'(n / 16));
        chk("word_wdata", 32'(wd[0]), 32'(dat));
        chk("word_ready", 32'(in_ready), (n == 255) ? 32'd0 : 32'd1);
        chk("word_finish", 32'(finish), 32'd0);
        n++;
      end else begin
        chk("bubble_we", 32'(wevec()), 32'd0);
      end
    end
    start = 1'b0;
    if (cyc >= 4000) begin
      nvec++;
      nerr++;
      $display("FAIL stream_timeout: got %0d words want %0d", n, n1);
    end
  endtask

  task automatic tail(input bit start_in_fin);
    in_valid = 1'b1;
    step();
    chk("fin_pulse", 32'(finish), 32'd1);
    chk("fin_we", 32'(wevec()), 32'd0);
    chk("fin_ready", 32'(in_ready), 32'd0);
    if (start_in_fin) start = 1'b1;
    step();
    chk("post_fin", 32'(finish), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd0);
    chk("post_we", 32'(wevec()), 32'd0);
  endtask

  task automatic check_banks(input int id);
    for (int k = 0; k < 16; k++)
      for (int a = 0; a < 16; a++) begin
        chk("bank_tag", 32'(tag[k][a]), 32'(id));
        chk("bank_data", 32'(mem[k][a]), 32'(8'(16 * a + k) ^ 8'h80));
      end
  endtask

  typedef struct {
    logic        xrst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic [15:0] we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        fin;
  } vec_t;

  vec_t tbl [15];
  int   wr0;
  int   fin0;

  initial begin
    xrst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 16'h0000, 4'h0, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 16'h0001, 4'h0, 8'h80, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 16'h0002, 4'h0, 8'h7F, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 16'h0000, 4'h0, 8'h7F, 1'b0};

    load_id = 1;
    for (int i = 0; i < 15; i++) begin
      xrst     = tbl[i].xrst;
      start    = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      step();
      chk("tbl_ready",  32'(in_ready), 32'(tbl[i].rdy));
      chk("tbl_we",     32'(wevec()),  32'(tbl[i].we));
      chk("tbl_waddr",  32'(wa[0]),    32'(tbl[i].wa));
      chk("tbl_wdata",  32'(wd[0]),    32'(tbl[i].wd));
      chk("tbl_finish", 32'(finish),   32'(tbl[i].fin));
    end

    // Continue to 37 words total, then reset asynchronously mid-cycle.
    stream(1'b0, 2, 37, 1'b0);
    chk("pre_rst_we", 32'(wevec()), 32'(16'h0010));
    xrst = 1'b0;
    #1;
    chk("rst_we", 32'(wevec()), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_waddr", 32'(wa[0]), 32'd0);
    chk("rst_wdata", 32'(wd[0]), 32'd0);
    wr0 = wr_cnt;
    in_valid = 1'b1;
    start = 1'b1;
    repeat (3) step();
    chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_hold_ready", 32'(in_ready), 32'd0);
    xrst = 1'b1;
    start = 1'b0;
    step();
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Full continuous load with a stray start at word 100.
    load_id = 2;
    wr0 = wr_cnt;
    fin0 = fin_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    stream(1'b0, 0, 256, 1'b1);
    chk("last_we15", 32'(we_u[15]), 32'd1);
    tail(1'b1);
    step();
    chk("b2b_start_ready", 32'(in_ready), 32'd1);
    start = 1'b0;
    chk("load2_writes", 32'(wr_cnt - wr0), 32'd256);
    chk("load2_finish", 32'(fin_cnt - fin0), 32'd1);
    chk("w4_a6_word100", 32'(mem[4][6]), 32'(8'd100 ^ 8'h80));
    check_banks(2);

    // Back-to-back load with bubbles 1,0,0.
    load_id = 3;
    wr0 = wr_cnt;
    fin0 = fin_cnt;
    stream(1'b1, 0, 256, 1'b0);
    tail(1'b0);
    step();
    chk("idle_after_load3", 32'(in_ready), 32'd0);
    chk("load3_writes", 32'(wr_cnt - wr0), 32'd256);
    chk("load3_finish", 32'(fin_cnt - fin0), 32'd1);
    check_banks(3);

    chk("multi_hot_we", 32'(multi_hot), 32'd0);
    chk("broadcast", 32'(bcast_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
